// File: rtl/cpuregs_wb_unit_pkg.sv
// Shared types and helpers for the register-file writeback stage.
// Load size encodings, FSM state type, and the load data extractor.
// Pure combinational helpers; no state lives here.
package cpuregs_pkg;

  localparam logic [1:0] LD_BYTE = 2'd0;
  localparam logic [1:0] LD_HALF = 2'd1;
  localparam logic [1:0] LD_WORD = 2'd2;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_t;

  // Size 3 is reserved and behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      LD_BYTE: return 1'b0;
      LD_HALF: return addr_lo[0];
      default: return (addr_lo != 2'd0);
    endcase
  endfunction

  // Pick the addressed byte/half out of a little-endian word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] size,
                                               input logic sgn, input logic [1:0] addr_lo);
    logic [7:0]  b;
    logic [15:0] h;
    case (addr_lo)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      LD_BYTE: return {{24{sgn & b[7]}}, b};
      LD_HALF: return {{16{sgn & h[15]}}, h};
      default: return rdata;
    endcase
  endfunction

endpackage

// File: rtl/cpuregs_wb_unit_if.sv
// Bundle of ALU, load/memory and register-file write signals for the writeback stage.
// No logic; carries combinational and registered signals unchanged.
// Backpressure is alu_wr_ready only; loads are tracked by ld_busy.
interface cpuregs_wb_unit_if #(
  parameter int REGINDEX_BITS = 5
);
  logic                     trap;
  logic                     alu_wr_valid;
  logic                     alu_wr_ready;
  logic [REGINDEX_BITS-1:0] alu_wr_rd;
  logic [31:0]              alu_wr_data;
  logic                     ld_start;
  logic [REGINDEX_BITS-1:0] ld_rd;
  logic [1:0]               ld_size;
  logic                     ld_signed;
  logic [1:0]               ld_addr_lo;
  logic                     ld_busy;
  logic                     mem_ready;
  logic [31:0]              mem_rdata;
  logic                     ld_misalign;
  logic                     ld_protocol_err;
  logic                     cpuregs_write;
  logic [31:0]              cpuregs_wrdata;
  logic [REGINDEX_BITS-1:0] latched_rd;

  modport master (
    output trap, alu_wr_valid, alu_wr_rd, alu_wr_data,
    output ld_start, ld_rd, ld_size, ld_signed, ld_addr_lo, mem_ready, mem_rdata,
    input  alu_wr_ready, ld_busy, ld_misalign, ld_protocol_err,
    input  cpuregs_write, cpuregs_wrdata, latched_rd
  );

  modport slave (
    input  trap, alu_wr_valid, alu_wr_rd, alu_wr_data,
    input  ld_start, ld_rd, ld_size, ld_signed, ld_addr_lo, mem_ready, mem_rdata,
    output alu_wr_ready, ld_busy, ld_misalign, ld_protocol_err,
    output cpuregs_write, cpuregs_wrdata, latched_rd
  );
endinterface

// File: rtl/cpuregs_wb_unit_skid.sv
// One-entry skid buffer for ALU results that lose the write port to a load.
// Holds an entry for at least one cycle; drains on the first cycle hold is low.
// in_rdy = !full, so an occupied entry can never be overwritten.
module cpuregs_wb_skid #(
  parameter int REGINDEX_BITS = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [REGINDEX_BITS-1:0] in_rd,
  input  logic [31:0]              in_dat,
  input  logic                     hold,
  output logic                     out_vld,
  output logic [REGINDEX_BITS-1:0] out_rd,
  output logic [31:0]              out_dat
);
  logic full;

  assign in_rdy  = !full;
  assign out_vld = full;

  // Capture only when the write port is taken; release once it is free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full    <= 1'b0;
      out_rd  <= '0;
      out_dat <= '0;
    end else if (full) begin
      if (!hold) full <= 1'b0;
    end else if (in_vld && hold) begin
      full    <= 1'b1;
      out_rd  <= in_rd;
      out_dat <= in_dat;
    end
  end
endmodule

// File: rtl/cpuregs_wb_unit.sv
// Writeback merge of ALU results and load completions into the register-file write port.
// Latency: load/ALU event in cycle N writes in N+1; ALU delayed by a load writes in N+2.
// Backpressure: alu_wr_ready drops only while the skid entry is occupied.
module cpuregs_wb_unit #(
  parameter int REGINDEX_BITS  = 5,
  parameter bit CATCH_MISALIGN = 1'b1
) (
  input logic              clk,
  input logic              reset,
  cpuregs_wb_unit_if.slave bus
);
  import cpuregs_pkg::*;

  wb_state_t                state;
  logic [REGINDEX_BITS-1:0] ld_rd_q;
  logic [1:0]               ld_size_q;
  logic [1:0]               ld_addr_q;
  logic                     ld_signed_q;
  logic                     misalign_q;
  logic                     proto_err_q;

  logic                     ld_done;
  logic                     alu_fire;
  logic                     skid_vld;
  logic [REGINDEX_BITS-1:0] skid_rd;
  logic [31:0]              skid_dat;

  logic                     wb_vld;
  logic [REGINDEX_BITS-1:0] wb_rd;
  logic [31:0]              wb_dat;

  // trap wins over a same-cycle mem_ready: the load is dropped.
  assign ld_done  = (state == WAIT_MEM) && bus.mem_ready && !bus.trap;
  assign alu_fire = bus.alu_wr_valid && bus.alu_wr_ready;

  assign bus.ld_busy         = (state == WAIT_MEM);
  assign bus.ld_misalign     = misalign_q;
  assign bus.ld_protocol_err = proto_err_q;

  cpuregs_wb_skid #(.REGINDEX_BITS(REGINDEX_BITS)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (bus.alu_wr_valid),
    .in_rdy  (bus.alu_wr_ready),
    .in_rd   (bus.alu_wr_rd),
    .in_dat  (bus.alu_wr_data),
    .hold    (ld_done),
    .out_vld (skid_vld),
    .out_rd  (skid_rd),
    .out_dat (skid_dat)
  );

  // Select this cycle's write source: load > skid entry > live ALU handshake.
  always_comb begin
    wb_vld = 1'b0;
    wb_rd  = '0;
    wb_dat = '0;
    if (ld_done) begin
      wb_vld = 1'b1;
      wb_rd  = ld_rd_q;
      wb_dat = load_extract(bus.mem_rdata, ld_size_q, ld_signed_q, ld_addr_q);
    end else if (skid_vld) begin
      wb_vld = 1'b1;
      wb_rd  = skid_rd;
      wb_dat = skid_dat;
    end else if (alu_fire) begin
      wb_vld = 1'b1;
      wb_rd  = bus.alu_wr_rd;
      wb_dat = bus.alu_wr_data;
    end
  end

  // Register the write port; x0 writes are consumed but never strobed, data/index hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.cpuregs_write  <= 1'b0;
      bus.cpuregs_wrdata <= '0;
      bus.latched_rd     <= '0;
    end else begin
      bus.cpuregs_write <= wb_vld && (wb_rd != '0);
      if (wb_vld && (wb_rd != '0)) begin
        bus.cpuregs_wrdata <= wb_dat;
        bus.latched_rd     <= wb_rd;
      end
    end
  end

  // Outstanding-load tracker with registered error pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ld_rd_q     <= '0;
      ld_size_q   <= LD_BYTE;
      ld_addr_q   <= 2'd0;
      ld_signed_q <= 1'b0;
      misalign_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      misalign_q  <= 1'b0;
      proto_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ld_start) begin
            if (CATCH_MISALIGN && is_misaligned(bus.ld_size, bus.ld_addr_lo)) begin
              misalign_q <= 1'b1;
            end else begin
              state       <= WAIT_MEM;
              ld_rd_q     <= bus.ld_rd;
              ld_size_q   <= bus.ld_size;
              ld_addr_q   <= bus.ld_addr_lo;
              ld_signed_q <= bus.ld_signed;
            end
          end
        end
        default: begin
          if (bus.ld_start) proto_err_q <= 1'b1;
          if (bus.trap || bus.mem_ready) state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cpuregs_wb_unit.sv
// Self-checking bench for cpuregs_wb_unit: directed scenarios then random traffic.
// Reference model: loads preempt a FIFO of accepted ALU results, one write per cycle.
// Outputs sampled 1 time unit after the rising edge.
module tb_cpuregs_wb_unit;
  localparam int RB = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpuregs_wb_unit_if #(.REGINDEX_BITS(RB)) bus ();

  cpuregs_wb_unit #(.REGINDEX_BITS(RB), .CATCH_MISALIGN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] dat;
  } wr_t;

  wr_t         aq[$];
  bit          m_busy;
  logic [4:0]  m_rd;
  logic [1:0]  m_size, m_addr;
  bit          m_sgn;
  logic        e_wr;
  logic [31:0] e_dat;
  logic [4:0]  e_rd;
  bit          e_mis, e_perr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [1:0] size,
                                           input bit sgn, input logic [1:0] a);
    int unsigned v;
    if (size == 2'd0) begin
      v = (d >> (8 * a)) & 32'hFF;
      if (sgn && v >= 128) v = v - 256;
    end else if (size == 2'd1) begin
      v = (d >> (a[1] ? 16 : 0)) & 32'hFFFF;
      if (sgn && v >= 32768) v = v - 65536;
    end else begin
      v = d;
    end
    return v;
  endfunction

  function automatic bit ref_mis(input logic [1:0] size, input logic [1:0] a);
    return (size == 2'd1 && a[0]) || (size >= 2'd2 && a != 2'd0);
  endfunction

  task automatic emit(input logic [4:0] rd, input logic [31:0] d);
    if (rd != 5'd0) begin
      e_wr  = 1'b1;
      e_dat = d;
      e_rd  = rd;
    end
  endtask

  task automatic model_reset();
    aq.delete();
    m_busy = 0; m_rd = 0; m_size = 0; m_addr = 0; m_sgn = 0;
    e_wr = 0; e_dat = 0; e_rd = 0; e_mis = 0; e_perr = 0;
  endtask

  task automatic idle_inputs();
    bus.trap = 0; bus.alu_wr_valid = 0; bus.alu_wr_rd = 0; bus.alu_wr_data = 0;
    bus.ld_start = 0; bus.ld_rd = 0; bus.ld_size = 0; bus.ld_signed = 0; bus.ld_addr_lo = 0;
    bus.mem_ready = 0; bus.mem_rdata = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_write"}, bus.cpuregs_write, 0);
    chk({tag, "_wrdata"}, bus.cpuregs_wrdata, 0);
    chk({tag, "_rd"}, bus.latched_rd, 0);
    chk({tag, "_busy"}, bus.ld_busy, 0);
    chk({tag, "_mis"}, bus.ld_misalign, 0);
    chk({tag, "_perr"}, bus.ld_protocol_err, 0);
    chk({tag, "_ready"}, bus.alu_wr_ready, 1);
  endtask

  // Predict one clock from the currently driven inputs, clock it, compare.
  task automatic step();
    bit  rdy, done, acc;
    wr_t w;
    rdy = (aq.size() == 0);
    chk("alu_wr_ready", bus.alu_wr_ready, rdy);
    done = m_busy && bus.mem_ready && !bus.trap;
    acc  = bus.alu_wr_valid && rdy;
    e_wr = 1'b0;
    if (done) begin
      emit(m_rd, ref_load(bus.mem_rdata, m_size, m_sgn, m_addr));
      if (acc) aq.push_back('{bus.alu_wr_rd, bus.alu_wr_data});
    end else if (aq.size() > 0) begin
      w = aq.pop_front();
      emit(w.rd, w.dat);
    end else if (acc) begin
      emit(bus.alu_wr_rd, bus.alu_wr_data);
    end
    e_mis  = 0;
    e_perr = 0;
    if (!m_busy) begin
      if (bus.ld_start) begin
        if (ref_mis(bus.ld_size, bus.ld_addr_lo)) e_mis = 1;
        else begin
          m_busy = 1; m_rd = bus.ld_rd; m_size = bus.ld_size;
          m_addr = bus.ld_addr_lo; m_sgn = bus.ld_signed;
        end
      end
    end else begin
      if (bus.ld_start) e_perr = 1;
      if (bus.trap || bus.mem_ready) m_busy = 0;
    end
    @(posedge clk);
    #1;
    chk("cpuregs_write", bus.cpuregs_write, e_wr);
    chk("cpuregs_wrdata", bus.cpuregs_wrdata, e_dat);
    chk("latched_rd", bus.latched_rd, e_rd);
    chk("ld_busy", bus.ld_busy, m_busy);
    chk("ld_misalign", bus.ld_misalign, e_mis);
    chk("ld_protocol_err", bus.ld_protocol_err, e_perr);
  endtask

  task automatic start_load(input logic [4:0] rd, input logic [1:0] size, input bit sgn,
                            input logic [1:0] a);
    bus.ld_start = 1; bus.ld_rd = rd; bus.ld_size = size; bus.ld_signed = sgn; bus.ld_addr_lo = a;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    // Signed byte load at addr_lo=3, data returned two cycles after issue.
    start_load(5'd9, 2'd0, 1, 2'd3);
    step();
    bus.ld_start = 0;
    step();
    bus.mem_ready = 1; bus.mem_rdata = 32'h80112233;
    step();
    chk("lb_sext_data", bus.cpuregs_wrdata, 32'hFFFFFF80);
    chk("lb_sext_rd", bus.latched_rd, 9);
    bus.mem_ready = 0;

    // Unsigned half at addr_lo=2, then a misaligned half.
    start_load(5'd3, 2'd1, 0, 2'd2);
    step();
    bus.ld_start = 0; bus.mem_ready = 1; bus.mem_rdata = 32'hBEEF0000;
    step();
    chk("lhu_data", bus.cpuregs_wrdata, 32'h0000BEEF);
    bus.mem_ready = 0;
    start_load(5'd3, 2'd1, 0, 2'd1);
    step();
    bus.ld_start = 0;
    chk("mis_pulse", bus.ld_misalign, 1);
    chk("mis_no_write", bus.cpuregs_write, 0);
    step();

    // ALU result colliding with a load completion is deferred one cycle.
    start_load(5'd7, 2'd2, 0, 2'd0);
    step();
    bus.ld_start = 0; bus.mem_ready = 1; bus.mem_rdata = 32'hCAFEF00D;
    bus.alu_wr_valid = 1; bus.alu_wr_rd = 5'd5; bus.alu_wr_data = 32'h1234;
    step();
    chk("coll_load_rd", bus.latched_rd, 7);
    chk("coll_ready_low", bus.alu_wr_ready, 0);
    bus.mem_ready = 0; bus.alu_wr_valid = 0;
    step();
    chk("coll_alu_rd", bus.latched_rd, 5);
    chk("coll_alu_data", bus.cpuregs_wrdata, 32'h1234);

    // trap beats mem_ready; ld_start while busy flags a protocol error.
    start_load(5'd4, 2'd2, 0, 2'd0);
    step();
    bus.trap = 1; bus.mem_ready = 1; bus.mem_rdata = 32'h11111111;
    step();
    chk("trap_no_write", bus.cpuregs_write, 0);
    chk("trap_busy", bus.ld_busy, 0);
    chk("perr_pulse", bus.ld_protocol_err, 1);
    idle_inputs();
    step();

    // x0 writes are swallowed; the next ALU write is unaffected.
    bus.alu_wr_valid = 1; bus.alu_wr_rd = 5'd0; bus.alu_wr_data = 32'hFFFFFFFF;
    step();
    chk("x0_no_write", bus.cpuregs_write, 0);
    bus.alu_wr_rd = 5'd1; bus.alu_wr_data = 32'h55;
    step();
    chk("x1_write", bus.cpuregs_write, 1);
    chk("x1_data", bus.cpuregs_wrdata, 32'h55);
    bus.alu_wr_valid = 0;

    // Async reset while the skid holds an entry: pending write dropped.
    start_load(5'd6, 2'd2, 0, 2'd0);
    step();
    bus.ld_start = 0; bus.mem_ready = 1; bus.mem_rdata = 32'h600D600D;
    bus.alu_wr_valid = 1; bus.alu_wr_rd = 5'd8; bus.alu_wr_data = 32'h77;
    step();
    idle_inputs();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_reset_outputs("arst_skid");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    chk("arst_skid_dropped", bus.cpuregs_write, 0);

    // Async reset mid-load; a late mem_ready must not write.
    start_load(5'd12, 2'd2, 0, 2'd0);
    step();
    bus.ld_start = 0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_reset_outputs("arst_load");
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.mem_ready = 1; bus.mem_rdata = 32'hDEADBEEF;
    step();
    chk("late_mem_no_write", bus.cpuregs_write, 0);
    step();
    bus.mem_ready = 0;

    // Back-to-back load issued in the first IDLE cycle after completion.
    start_load(5'd13, 2'd0, 0, 2'd1);
    step();
    bus.ld_start = 0; bus.mem_ready = 1; bus.mem_rdata = 32'h0000A500;
    step();
    start_load(5'd14, 2'd1, 1, 2'd0);
    bus.mem_ready = 0;
    step();
    chk("b2b_busy", bus.ld_busy, 1);
    bus.ld_start = 0; bus.mem_ready = 1; bus.mem_rdata = 32'h00008001;
    step();
    chk("b2b_data", bus.cpuregs_wrdata, 32'hFFFF8001);
    idle_inputs();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bus.alu_wr_valid = ($urandom_range(0, 1) == 1);
      bus.alu_wr_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      bus.alu_wr_data  = $urandom;
      bus.ld_start     = ($urandom_range(0, 3) == 0);
      bus.ld_rd        = 5'($urandom);
      bus.ld_size      = 2'($urandom);
      bus.ld_signed    = 1'($urandom);
      bus.ld_addr_lo   = 2'($urandom);
      bus.mem_ready    = ($urandom_range(0, 2) == 0);
      bus.mem_rdata    = $urandom;
      bus.trap         = ($urandom_range(0, 15) == 0);
      step();
    end
    idle_inputs();
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
